// File: rtl/slider_move_ctrl_if.sv
// Key/demo request levels in, slider step pulses and status out.
// The controller takes the slave side; key/demo logic and the slider share the master side.
interface slider_move_ctrl_if;
    logic       iKey_go;
    logic       iKey_back;
    logic       iKey_up;
    logic       iKey_down;
    logic       iAuto_go;
    logic       iAuto_back;
    logic       iAuto_up;
    logic       iAuto_down;
    logic       oSlider_go;
    logic       oSlider_back;
    logic       oSlider_up;
    logic       oSlider_down;
    logic [1:0] oMode;
    logic       oFrame_tick;

    modport slave (
        input  iKey_go, iKey_back, iKey_up, iKey_down,
        input  iAuto_go, iAuto_back, iAuto_up, iAuto_down,
        output oSlider_go, oSlider_back, oSlider_up, oSlider_down,
        output oMode, oFrame_tick
    );

    modport master (
        output iKey_go, iKey_back, iKey_up, iKey_down,
        output iAuto_go, iAuto_back, iAuto_up, iAuto_down,
        input  oSlider_go, oSlider_back, oSlider_up, oSlider_down,
        input  oMode, oFrame_tick
    );
endinterface

// File: rtl/slider_move_ctrl.sv
// Arbitrates player/demo motion requests and issues frame-rate-limited
// one-clock step pulses to the slider.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | no key recently, waiting for timeout or a key
// S_PLAYER | keys drive the slider
// S_DEMO   | automatic source drives the slider
// S_PAUSE  | frozen, no steps issued
module slider_move_ctrl #(
    parameter int unsigned FRAMES_PER_STEP = 1,
    parameter int unsigned IDLE_TIMEOUT    = 600
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               iVS,
    input  logic               iFreeze,
    slider_move_ctrl_if.slave  bus
);

    localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);
    localparam logic [9:0] IDLE_MAX  = 10'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_PLAYER = 2'b01,
        S_DEMO   = 2'b10,
        S_PAUSE  = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       vs_q, vs_d;
    logic       armed_q, armed_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic [9:0] idle_cnt_q, idle_cnt_d;
    logic [3:0] pulse_q, pulse_d;

    logic       tick;
    logic       step_en;
    logic       any_key;
    logic [3:0] key_req;
    logic [3:0] auto_req;
    logic [3:0] src_req;

    assign key_req  = {bus.iKey_go, bus.iKey_back, bus.iKey_up, bus.iKey_down};
    assign auto_req = {bus.iAuto_go, bus.iAuto_back, bus.iAuto_up, bus.iAuto_down};
    assign any_key  = |key_req;

    // armed_q blocks the spurious edge seen when reset releases while iVS is low
    assign tick    = armed_q & vs_q & ~iVS;
    assign step_en = tick & (frame_cnt_q == STEP_LAST);

    always_comb begin
        vs_d        = iVS;
        armed_d     = 1'b1;
        frame_cnt_d = frame_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        if (tick) begin
            frame_cnt_d = (frame_cnt_q == STEP_LAST) ? 8'd0 : frame_cnt_q + 8'd1;
        end
        if (any_key || (state_q == S_PAUSE && !iFreeze)) begin
            idle_cnt_d = 10'd0;
        end else if (tick && idle_cnt_q < IDLE_MAX) begin
            idle_cnt_d = idle_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_q        <= 1'b1;
            armed_q     <= 1'b0;
            frame_cnt_q <= 8'd0;
            idle_cnt_q  <= 10'd0;
            pulse_q     <= 4'd0;
        end else begin
            vs_q        <= vs_d;
            armed_q     <= armed_d;
            frame_cnt_q <= frame_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (iFreeze) begin
            state_d = S_PAUSE;
        end else if (state_q == S_PAUSE) begin
            state_d = S_IDLE;
        end else if (any_key) begin
            state_d = S_PLAYER;
        end else if (idle_cnt_q == IDLE_MAX && state_q != S_DEMO) begin
            state_d = S_DEMO;
        end
    end

    // Source follows the pre-transition state; opposing requests on an axis cancel.
    always_comb begin
        src_req = 4'd0;
        case (state_q)
            S_PLAYER: src_req = key_req;
            S_DEMO:   src_req = auto_req;
            default:  src_req = 4'd0;
        endcase
        pulse_d = {src_req[3] & ~src_req[2],
                   src_req[2] & ~src_req[3],
                   src_req[1] & ~src_req[0],
                   src_req[0] & ~src_req[1]} & {4{step_en}};
    end

    assign bus.oSlider_go   = pulse_q[3];
    assign bus.oSlider_back = pulse_q[2];
    assign bus.oSlider_up   = pulse_q[1];
    assign bus.oSlider_down = pulse_q[0];
    assign bus.oMode        = state_q;
    assign bus.oFrame_tick  = tick;

endmodule
